// File: rtl/falu_fcvt_wb_buffer_if.sv
// Handshake bundle between the FCVT datapath, the result buffer and the FP
// writeback port. The producer/consumer side uses the master modport; the
// buffer itself uses the slave modport.
interface falu_fcvt_wb_buffer_if #(
    parameter int ROB_W = 6
);
    // Conversion-result side
    logic             in_valid;
    logic             in_ready;
    logic [ROB_W-1:0] in_rob_tag;
    logic [4:0]       in_rd;
    logic             in_is_double;
    logic [63:0]      in_src;
    logic [63:0]      in_result;
    logic             in_overflow;
    logic             in_underflow;
    logic             in_inexact;

    // Writeback side
    logic             wb_valid;
    logic             wb_ready;
    logic [ROB_W-1:0] wb_rob_tag;
    logic [4:0]       wb_rd;
    logic [63:0]      wb_data;
    logic [4:0]       wb_fflags;

    modport master (
        output in_valid, in_rob_tag, in_rd, in_is_double, in_src, in_result,
               in_overflow, in_underflow, in_inexact, wb_ready,
        input  in_ready, wb_valid, wb_rob_tag, wb_rd, wb_data, wb_fflags
    );

    modport slave (
        input  in_valid, in_rob_tag, in_rd, in_is_double, in_src, in_result,
               in_overflow, in_underflow, in_inexact, wb_ready,
        output in_ready, wb_valid, wb_rob_tag, wb_rd, wb_data, wb_fflags
    );
endinterface

// File: rtl/falu_fcvt_wb_buffer.sv
// FCVT.S.D / FCVT.D.S writeback buffer.
// Forms RISC-V fflags for each conversion result at capture time, queues the
// results in a small FIFO for the FP writeback port and keeps the sticky
// accumulated-fflags value for the FCSR.
module falu_fcvt_wb_buffer #(
    parameter int DEPTH = 2,
    parameter int ROB_W = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   fflags_clr,
    output logic [4:0]             acc_fflags,
    falu_fcvt_wb_buffer_if.slave   bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [63:0] CANON_DP_QNAN = 64'h7FF8000000000000;

    // Flag formation for one conversion. NaN sources suppress the converter's
    // OF/UF/NX; a signalling-NaN source raises NV. A non-NaN-boxed SP source is
    // treated as the canonical quiet NaN.
    function automatic logic [4:0] form_fflags(
        input logic        is_double,
        input logic [63:0] src,
        input logic        ovf,
        input logic        unf,
        input logic        inx
    );
        logic boxed;
        logic src_nan;
        logic src_snan;
        logic of_f;
        logic uf_f;
        logic nx_f;
        if (is_double) begin
            boxed    = (src[63:32] == 32'hFFFF_FFFF);
            src_nan  = !boxed || ((src[30:23] == 8'hFF) && (src[22:0] != 23'd0));
            src_snan = boxed && (src[30:23] == 8'hFF) && (src[22:0] != 23'd0) && !src[22];
            of_f     = 1'b0;
            uf_f     = 1'b0;
            nx_f     = 1'b0;
        end else begin
            boxed    = 1'b1;
            src_nan  = (src[62:52] == 11'h7FF) && (src[51:0] != 52'd0);
            src_snan = src_nan && !src[51];
            of_f     = ovf & ~src_nan;
            uf_f     = unf & ~src_nan;
            nx_f     = (inx | of_f) & ~src_nan;
        end
        return {src_snan, 1'b0, of_f, uf_f, nx_f};
    endfunction

    // FIFO storage and control state
    logic [ROB_W-1:0] r_tag   [DEPTH];
    logic [4:0]       r_rd    [DEPTH];
    logic [63:0]      r_data  [DEPTH];
    logic [4:0]       r_flags [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [4:0]       r_acc;

    logic             w_in_ready;
    logic             w_wb_valid;
    logic             w_push;
    logic             w_pop;
    logic [4:0]       w_fflags;
    logic [63:0]      w_data;

    // Handshake qualifiers come only from registered occupancy
    assign w_in_ready = (r_count != FULL_CNT);
    assign w_wb_valid = (r_count != {CNT_W{1'b0}});
    assign w_push     = bus.in_valid & w_in_ready;
    assign w_pop      = w_wb_valid & bus.wb_ready;

    // Flags and write data for the entry being captured this cycle
    always_comb begin
        w_fflags = form_fflags(bus.in_is_double, bus.in_src, bus.in_overflow,
                               bus.in_underflow, bus.in_inexact);
        if (bus.in_is_double && (bus.in_src[63:32] != 32'hFFFF_FFFF)) begin
            w_data = CANON_DP_QNAN;
        end else begin
            w_data = bus.in_result;
        end
    end

    // Entry storage: written on an accepted push unless flushed the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i]   <= {ROB_W{1'b0}};
                r_rd[i]    <= 5'd0;
                r_data[i]  <= 64'd0;
                r_flags[i] <= 5'd0;
            end
        end else if (w_push && !flush) begin
            r_tag[r_wr_ptr]   <= bus.in_rob_tag;
            r_rd[r_wr_ptr]    <= bus.in_rd;
            r_data[r_wr_ptr]  <= w_data;
            r_flags[r_wr_ptr] <= w_fflags;
        end
    end

    // Pointers, occupancy and sticky flags; flush empties the queue and
    // keeps the accumulated flags apart from an explicit clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_acc    <= 5'd0;
        end else if (flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_acc    <= fflags_clr ? 5'd0 : r_acc;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_acc <= (fflags_clr ? 5'd0 : r_acc) | (w_pop ? r_flags[r_rd_ptr] : 5'd0);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.wb_valid   = w_wb_valid;
    assign bus.wb_rob_tag = r_tag[r_rd_ptr];
    assign bus.wb_rd      = r_rd[r_rd_ptr];
    assign bus.wb_data    = r_data[r_rd_ptr];
    assign bus.wb_fflags  = r_flags[r_rd_ptr];
    assign acc_fflags     = r_acc;

endmodule

// File: tb/tb_falu_fcvt_wb_buffer.sv
// Self-checking bench for falu_fcvt_wb_buffer: a vector table of single
// conversions plus hand-written full/ordering/flush/clear/reset sequences.
module tb_falu_fcvt_wb_buffer;

    localparam int DEPTH = 2;
    localparam int ROB_W = 6;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       fflags_clr;
    logic [4:0] acc_fflags;

    int n_checks;
    int n_err;

    falu_fcvt_wb_buffer_if #(.ROB_W(ROB_W)) bus ();

    falu_fcvt_wb_buffer #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fflags_clr (fflags_clr),
        .acc_fflags (acc_fflags),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [63:0] src;
        logic [63:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        logic [63:0] exp_data;
        logic [4:0]  exp_fl;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [5:0] tag, input logic is_d,
                          input logic [63:0] src, input logic [63:0] res,
                          input logic o, input logic u, input logic x);
        bus.in_valid     = v;
        bus.in_rob_tag   = tag;
        bus.in_rd        = tag[4:0];
        bus.in_is_double = is_d;
        bus.in_src       = src;
        bus.in_result    = res;
        bus.in_overflow  = o;
        bus.in_underflow = u;
        bus.in_inexact   = x;
    endtask

    logic [4:0] exp_acc;
    logic [5:0] q[$];

    initial begin
        n_checks = 0;
        n_err    = 0;
        //                   is_d  src                    result                 o     u     x     exp_data               exp_fl
        vecs[0]  = '{1'b0, 64'h3FF0000000000000, 64'hFFFFFFFF3F800000, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF3F800000, 5'b00000};
        vecs[1]  = '{1'b0, 64'h7FF0000000000001, 64'hFFFFFFFF7FC00000, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFF7FC00000, 5'b10000};
        vecs[2]  = '{1'b1, 64'h000000007F800001, 64'h0000000000001234, 1'b0, 1'b0, 1'b0, 64'h7FF8000000000000, 5'b00000};
        vecs[3]  = '{1'b0, 64'h47F0000000000000, 64'hFFFFFFFF7F800000, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFF7F800000, 5'b00101};
        vecs[4]  = '{1'b0, 64'h7FF8000000000000, 64'hFFFFFFFF7FC00000, 1'b1, 1'b1, 1'b1, 64'hFFFFFFFF7FC00000, 5'b00000};
        vecs[5]  = '{1'b1, 64'hFFFFFFFF7F800001, 64'h7FF8000000000000, 1'b0, 1'b0, 1'b0, 64'h7FF8000000000000, 5'b10000};
        vecs[6]  = '{1'b1, 64'hFFFFFFFF7FC00000, 64'h7FF8000000000000, 1'b0, 1'b0, 1'b0, 64'h7FF8000000000000, 5'b00000};
        vecs[7]  = '{1'b0, 64'h3800000000000001, 64'hFFFFFFFF00000001, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFF00000001, 5'b00011};
        vecs[8]  = '{1'b1, 64'hFFFFFFFF3F800000, 64'h3FF0000000000000, 1'b1, 1'b1, 1'b1, 64'h3FF0000000000000, 5'b00000};
        vecs[9]  = '{1'b0, 64'h3FF0000000000001, 64'hFFFFFFFF3F800000, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFF3F800000, 5'b00001};
        vecs[10] = '{1'b0, 64'h7FF0000000000000, 64'hFFFFFFFF7F800000, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF7F800000, 5'b00000};

        rst_n = 1'b0;
        flush = 1'b0;
        fflags_clr = 1'b0;
        bus.wb_ready = 1'b0;
        set_in(1'b0, 6'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);

        // Reset values
        #12;
        check("rst_in_ready",  64'(bus.in_ready),   64'd1);
        check("rst_wb_valid",  64'(bus.wb_valid),   64'd0);
        check("rst_wb_tag",    64'(bus.wb_rob_tag), 64'd0);
        check("rst_wb_rd",     64'(bus.wb_rd),      64'd0);
        check("rst_wb_data",   bus.wb_data,         64'd0);
        check("rst_wb_fflags", 64'(bus.wb_fflags),  64'd0);
        check("rst_acc",       64'(acc_fflags),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Vector table: push one, see it next cycle, pop it, check sticky flags
        exp_acc = 5'd0;
        for (int i = 0; i < NV; i++) begin
            check("vec_empty_before", 64'(bus.wb_valid), 64'd0);
            set_in(1'b1, 6'(i + 1), vecs[i].is_d, vecs[i].src, vecs[i].res,
                   vecs[i].ovf, vecs[i].unf, vecs[i].inx);
            step();
            bus.in_valid = 1'b0;
            check("vec_wb_valid", 64'(bus.wb_valid),   64'd1);
            check("vec_wb_tag",   64'(bus.wb_rob_tag), 64'(i + 1));
            check("vec_wb_rd",    64'(bus.wb_rd),      64'(i + 1));
            check("vec_wb_data",  bus.wb_data,         vecs[i].exp_data);
            check("vec_wb_fflags",64'(bus.wb_fflags),  64'(vecs[i].exp_fl));
            bus.wb_ready = 1'b1;
            step();
            bus.wb_ready = 1'b0;
            exp_acc = exp_acc | vecs[i].exp_fl;
            check("vec_wb_valid_after_pop", 64'(bus.wb_valid), 64'd0);
            check("vec_acc", 64'(acc_fflags), 64'(exp_acc));
        end
        check("acc_total", 64'(acc_fflags), 64'(5'b10111));

        // Fill to DEPTH with writeback stalled
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 6'(i + 1), 1'b0, 64'h3FF0000000000000, 64'hFFFFFFFF3F800000, 1'b0, 1'b0, 1'b0);
            step();
        end
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        // Push attempt while full must be dropped
        set_in(1'b1, 6'd63, 1'b0, 64'h3FF0000000000000, 64'hFFFFFFFF3F800000, 1'b0, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        check("full_still_full", 64'(bus.in_ready), 64'd0);
        check("full_head_tag", 64'(bus.wb_rob_tag), 64'd1);
        // Pop while full: in_ready rises only after the edge
        bus.wb_ready = 1'b1;
        #1;
        check("full_pop_same_cycle_ready", 64'(bus.in_ready), 64'd0);
        step();
        check("full_pop_next_ready", 64'(bus.in_ready), 64'd1);
        check("full_second_tag", 64'(bus.wb_rob_tag), 64'd2);

        // Simultaneous push/pop with one entry buffered
        q.delete();
        q.push_back(6'd2);
        for (int i = 0; i < 10; i++) begin
            check("pp_head_tag", 64'(bus.wb_rob_tag), 64'(q[0]));
            set_in(1'b1, 6'(20 + i), 1'b0, 64'h3FF0000000000000, 64'hFFFFFFFF3F800000, 1'b0, 1'b0, 1'b0);
            bus.wb_ready = 1'b1;
            step();
            void'(q.pop_front());
            q.push_back(6'(20 + i));
            check("pp_in_ready", 64'(bus.in_ready), 64'd1);
            check("pp_wb_valid", 64'(bus.wb_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        check("pp_last_tag", 64'(bus.wb_rob_tag), 64'(q[0]));
        step();
        bus.wb_ready = 1'b0;
        check("pp_drained", 64'(bus.wb_valid), 64'd0);
        check("pp_acc_hold", 64'(acc_fflags), 64'(exp_acc));

        // Flush with two sNaN entries buffered and a new push offered
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 6'(40 + i), 1'b0, 64'h7FF0000000000001, 64'hFFFFFFFF7FC00000, 1'b0, 1'b0, 1'b0);
            step();
        end
        set_in(1'b1, 6'd42, 1'b0, 64'h7FF0000000000001, 64'hFFFFFFFF7FC00000, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_acc", 64'(acc_fflags), 64'(exp_acc));
        // Flush with one entry: same-cycle push dropped, same-cycle pop not accumulated
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        check("clr_only_acc", 64'(acc_fflags), 64'd0);
        set_in(1'b1, 6'd43, 1'b0, 64'h7FF0000000000001, 64'hFFFFFFFF7FC00000, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 6'd44, 1'b0, 64'h3FF0000000000000, 64'hFFFFFFFF3F800000, 1'b0, 1'b0, 1'b1);
        bus.wb_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b0;
        check("flush_pop_acc", 64'(acc_fflags), 64'd0);
        step();
        check("flush_push_lost", 64'(bus.wb_valid), 64'd0);

        // Accumulate a flag, then clear coinciding with a pop of 5'b00001
        set_in(1'b1, 6'd45, 1'b0, 64'h7FF0000000000001, 64'hFFFFFFFF7FC00000, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 6'd46, 1'b0, 64'h3FF0000000000000, 64'hFFFFFFFF3F800000, 1'b0, 1'b0, 1'b1);
        bus.wb_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("acc_nv", 64'(acc_fflags), 64'(5'b10000));
        check("clr_pop_head_fl", 64'(bus.wb_fflags), 64'(5'b00001));
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        bus.wb_ready = 1'b0;
        check("clr_pop_acc", 64'(acc_fflags), 64'(5'b00001));

        // Asynchronous reset mid-operation
        set_in(1'b1, 6'd50, 1'b0, 64'h3FF0000000000000, 64'hFFFFFFFF3F800000, 1'b0, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_valid", 64'(bus.wb_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.wb_valid), 64'd0);
        check("async_rst_acc", 64'(acc_fflags), 64'd0);
        check("async_rst_data", bus.wb_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 64'(bus.in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/falu_fcvt_wb_buffer.md
Name: falu_fcvt_wb_buffer

Overview:
- Sits directly downstream of the FALU FP-to-FP conversion datapath (FCVT.S.D / FCVT.D.S).
- Captures each conversion result and its raw OVERFLOW/UNDERFLOW/INEXACT outputs together with the source operand.
- Forms the RISC-V fflags for the result (including invalid on a signalling-NaN source) and buffers results in a small FIFO for the FP writeback/commit port, using valid/ready handshakes on both sides.
- Maintains a sticky accumulated-fflags register for the FCSR.

Parameters:
- DEPTH, 2: FIFO entries; power of two, ≥2.
- ROB_W, 6: width of the ROB tag carried with each result.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; discards all buffered entries.
- in_valid  in  1  conversion result present.
- in_ready  out  1  buffer can accept this cycle.
- in_rob_tag  in  ROB_W  ROB tag of the instruction.
- in_rd  in  5  destination FP register.
- in_is_double  in  1  1 = SP→DP (output DP), 0 = DP→SP.
- in_src  in  64  source operand as read from the FP register file.
- in_result  in  64  converter OUTPUT (SP results already NaN-boxed).
- in_overflow  in  1  converter OVERFLOW.
- in_underflow  in  1  converter UNDERFLOW.
- in_inexact  in  1  converter INEXACT.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  writeback accepts the head entry.
- wb_rob_tag  out  ROB_W  head tag.
- wb_rd  out  5  head destination register.
- wb_data  out  64  head result.
- wb_fflags  out  5  head flags {NV,DZ,OF,UF,NX}.
- fflags_clr  in  1  clear the accumulated flags (CSR write).
- acc_fflags  out  5  sticky OR of all flags popped since the last clear.

Behaviour:
Reset values (while rst_n=0): in_ready=1, wb_valid=0, wb_rob_tag=0, wb_rd=0, wb_data=0, wb_fflags=0, acc_fflags=0; read/write pointers and count are 0.

Handshakes:
- Push on in_valid&in_ready. Pop on wb_valid&wb_ready.
- in_ready = (count != DEPTH), derived only from registered state.
- wb_valid = (count != 0).
- wb_* outputs are driven from the head entry.

Latency and ordering:
- An entry pushed in cycle N is visible on wb_valid in cycle N+1. There is no bypass.
- Results leave in strict FIFO order.

Flag formation (evaluated at push, stored in the entry):
- src_snan when in_is_double=0: in_src[62:52]=all ones, in_src[51:0]≠0, in_src[51]=0.
- src_snan when in_is_double=1: in_src[63:32]=all ones, in_src[30:23]=all ones, in_src[22:0]≠0, in_src[22]=0.
- An SP source that is not NaN-boxed (in_src[63:32]≠all ones) is a canonical qNaN, so src_snan=0.
- src_nan: the same tests without the quiet-bit condition. A non-boxed SP source counts as src_nan=1.
- NV = src_snan. DZ = 0.
- SP→DP: OF=UF=NX=0 (widening is exact).
- DP→SP: OF = in_overflow&~src_nan; UF = in_underflow&~src_nan; NX = (in_inexact|OF)&~src_nan.
- Data: if in_is_double=1 and the SP source is not NaN-boxed, wb_data = 64'h7FF8000000000000. Otherwise wb_data = in_result unchanged.

Accumulated flags:
- Updated each cycle: acc_fflags <= (fflags_clr ? 0 : acc_fflags) | (pop ? head fflags : 0).
- If clear and pop coincide, the result is exactly the popped flags.

Boundary conditions:
- Full: in_ready=0, so no push. A pop while full makes in_ready=1 in the next cycle, not the same cycle.
- Empty: wb_valid=0 and wb_ready is ignored.
- Push and pop in the same cycle (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- flush=1: next state is count=0 and pointers=0. A same-cycle push is dropped, and a same-cycle pop does not update acc_fflags. acc_fflags otherwise holds across a flush.
- rst_n falling mid-operation: all state clears immediately (asynchronous). Release is synchronous to clk.

Test Plan:
- DP→SP of 1.0 (in_src=64'h3FF0000000000000, in_result=64'hFFFFFFFF3F800000, flags 0) → wb_valid next cycle, wb_data=64'hFFFFFFFF3F800000, wb_fflags=5'b00000.
- DP→SP of sNaN in_src=64'h7FF0000000000001, in_overflow=1 → wb_fflags=5'b10000 (OF masked), acc_fflags=5'b10000 after the pop.
- SP→DP with in_src=64'h000000007F800001 (not boxed) → wb_data=64'h7FF8000000000000, wb_fflags=0.
- DP→SP with in_overflow=1, in_inexact=0, non-NaN source → wb_fflags=5'b00101.
- Hold wb_ready=0 and push DEPTH entries → in_ready=0 the cycle after the last push. Then push/pop simultaneously with count=1 for 10 cycles → tags emerge in order and count stays 1.
- Two entries buffered, assert flush together with in_valid → wb_valid=0 next cycle, the new entry is lost, acc_fflags unchanged. Then assert fflags_clr with a pop of flags 5'b00001 → acc_fflags=5'b00001.
